// File: rtl/cba_pkg.sv
// Shared defaults, parameter checks and the operation encoding used by
// the pipelined carry-bypass adder.
package cba_pkg;

  localparam int CBA_DEF_WIDTH = 32;
  localparam int CBA_DEF_BLOCK = 4;
  localparam int CBA_DEF_BPS   = 2;

  typedef enum logic {
    CBA_OP_ADD = 1'b0,
    CBA_OP_SUB = 1'b1
  } cba_op_e;

  // Number of register stages needed to resolve every skip block.
  function automatic int cba_num_stages(input int width, input int block, input int bps);
    return ((width / block) + bps - 1) / bps;
  endfunction

  function automatic bit cba_params_ok(input int width, input int block, input int bps);
    return (block >= 1) && (bps >= 1) && (width >= block) && ((width % block) == 0);
  endfunction

  localparam bit CBA_DEF_PARAMS_OK = cba_params_ok(CBA_DEF_WIDTH, CBA_DEF_BLOCK, CBA_DEF_BPS);
  localparam int CBA_DEF_STAGES    = cba_num_stages(CBA_DEF_WIDTH, CBA_DEF_BLOCK, CBA_DEF_BPS);

endpackage

// File: rtl/cba_pipe_adder_if.sv
// Streaming operand/result bus of the carry-bypass adder.
// The master drives operands and result backpressure; the slave is the adder.
interface cba_pipe_adder_if
  import cba_pkg::*;
#(
  parameter int WIDTH      = CBA_DEF_WIDTH,
  parameter int NUM_BLOCKS = CBA_DEF_WIDTH / CBA_DEF_BLOCK
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_a;
  logic [WIDTH-1:0]      in_b;
  logic                  in_cin;
  logic                  in_sub;

  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_sum;
  logic                  out_cout;
  logic                  out_ovf;
  logic [NUM_BLOCKS-1:0] out_skip_mask;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_skip_mask
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_skip_mask
  );

endinterface

// File: rtl/cba_skip_block.sv
// One BLOCK-bit carry-skip block: internal ripple chain plus a bypass mux
// that forwards cin straight to cout when every bit propagates.
module cba_skip_block
  import cba_pkg::*;
#(
  parameter int BLOCK = CBA_DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             skip
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;
  logic             rc;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    rc   = c[BLOCK];
    sum  = p ^ c[BLOCK-1:0];
    skip = &p;
    // When all bits propagate the ripple result equals cin; the mux shortens the critical path.
    cout = skip ? cin : rc;
  end

endmodule

// File: rtl/cba_pipe_adder.sv
// Pipelined carry-bypass adder/subtractor with a valid/ready stream on both sides.
// Each register stage resolves BLOCKS_PER_STAGE skip blocks; a single global stall freezes the pipe.
module cba_pipe_adder
  import cba_pkg::*;
#(
  parameter int WIDTH            = CBA_DEF_WIDTH,
  parameter int BLOCK            = CBA_DEF_BLOCK,
  parameter int BLOCKS_PER_STAGE = CBA_DEF_BPS
) (
  input  logic            clk,
  input  logic            rst_n,
  cba_pipe_adder_if.slave bus
);

  localparam int NUM_BLOCKS = WIDTH / BLOCK;
  localparam int STAGES     = cba_num_stages(WIDTH, BLOCK, BLOCKS_PER_STAGE);

  if (!cba_params_ok(WIDTH, BLOCK, BLOCKS_PER_STAGE)) begin : g_bad_params
    $error("cba_pipe_adder: WIDTH must be a multiple of BLOCK and BLOCKS_PER_STAGE must be >= 1");
  end

  typedef struct packed {
    logic                  valid;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b_eff;
    logic [WIDTH-1:0]      sum;
    logic                  carry;
    logic [NUM_BLOCKS-1:0] skip;
  } stage_t;

  stage_t src     [STAGES];
  stage_t stage_d [STAGES];
  stage_t stage_q [STAGES];

  logic [WIDTH-1:0]      blk_sum;
  logic [NUM_BLOCKS-1:0] blk_cout;
  logic [NUM_BLOCKS-1:0] blk_skip;

  logic    stall;
  logic    advance;
  cba_op_e op;

  assign op      = cba_op_e'(bus.in_sub);
  assign stall   = stage_q[STAGES-1].valid & ~bus.out_ready;
  assign advance = ~stall;

  // Stage 0 works on freshly prepared operands; later stages work on the previous register.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      src[s] = '0;
    end
    src[0].valid = bus.in_valid;
    src[0].a     = bus.in_a;
    src[0].b_eff = (op == CBA_OP_SUB) ? ~bus.in_b : bus.in_b;
    src[0].carry = bus.in_cin ^ (op == CBA_OP_SUB);
    for (int s = 1; s < STAGES; s++) begin
      src[s] = stage_q[s-1];
    end
  end

  for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_blk
    localparam int S = k / BLOCKS_PER_STAGE;

    logic             blk_cin;
    logic             cout;
    logic             skip;
    logic [BLOCK-1:0] sum;

    if ((k % BLOCKS_PER_STAGE) == 0) begin : g_stage_head
      assign blk_cin = src[S].carry;
    end else begin : g_chain
      assign blk_cin = g_blk[k-1].cout;
    end

    cba_skip_block #(
      .BLOCK (BLOCK)
    ) u_skip_block (
      .a    (src[S].a[k*BLOCK +: BLOCK]),
      .b    (src[S].b_eff[k*BLOCK +: BLOCK]),
      .cin  (blk_cin),
      .sum  (sum),
      .cout (cout),
      .skip (skip)
    );

    assign blk_sum[k*BLOCK +: BLOCK] = sum;
    assign blk_cout[k]               = cout;
    assign blk_skip[k]               = skip;
  end

  // Merge each stage's resolved blocks into its payload; the highest block of a stage sets the carry.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      stage_d[s] = src[s];
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        if ((k / BLOCKS_PER_STAGE) == s) begin
          stage_d[s].sum[k*BLOCK +: BLOCK] = blk_sum[k*BLOCK +: BLOCK];
          stage_d[s].skip[k]               = blk_skip[k];
          stage_d[s].carry                 = blk_cout[k];
        end
      end
    end
  end

  // Every stage holds together on a stall so bubbles keep their positions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else if (advance) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  assign bus.in_ready      = ~stall;
  assign bus.out_valid     = stage_q[STAGES-1].valid;
  assign bus.out_sum       = stage_q[STAGES-1].sum;
  assign bus.out_cout      = stage_q[STAGES-1].carry;
  assign bus.out_skip_mask = stage_q[STAGES-1].skip;
  assign bus.out_ovf       = (stage_q[STAGES-1].a[WIDTH-1] == stage_q[STAGES-1].b_eff[WIDTH-1]) &
                             (stage_q[STAGES-1].sum[WIDTH-1] != stage_q[STAGES-1].a[WIDTH-1]);

endmodule
